// File: rtl/nonce_scheduler_if.sv
// ============================================================================
// Module      : nonce_scheduler_if
// Description : Bundle of the job, pipeline-issue, hash-return and found-nonce
//               signals of the nonce scheduler.
//               master : job source / pipeline / found consumer (environment)
//               slave  : the scheduler itself
// Parameters  : WORD_S - nonce width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nonce_scheduler_if #(
    parameter int WORD_S = 32
);
    // job intake
    logic              job_valid;
    logic              job_ready;
    logic [WORD_S-1:0] job_nonce_start;
    logic [WORD_S-1:0] job_nonce_end;
    logic [255:0]      job_target;
    logic              abort;
    // pipeline issue / return
    logic              pipe_en;
    logic [WORD_S-1:0] pipe_nonce;
    logic              hash_valid;
    logic [255:0]      hash_in;
    // winning nonce
    logic              found_valid;
    logic [WORD_S-1:0] found_nonce;
    logic              found_ready;
    // status
    logic              busy;
    logic              done;
    logic              hit_lost;

    modport master (
        output job_valid, job_nonce_start, job_nonce_end, job_target, abort,
               hash_valid, hash_in, found_ready,
        input  job_ready, pipe_en, pipe_nonce, found_valid, found_nonce,
               busy, done, hit_lost
    );

    modport slave (
        input  job_valid, job_nonce_start, job_nonce_end, job_target, abort,
               hash_valid, hash_in, found_ready,
        output job_ready, pipe_en, pipe_nonce, found_valid, found_nonce,
               busy, done, hit_lost
    );
endinterface

`default_nettype wire

// File: rtl/nonce_scheduler.sv
// ============================================================================
// Module      : nonce_scheduler
// Description : Sequences one mining job through a fixed-latency double-SHA256
//               pipeline: issues one nonce per cycle, pairs each returning hash
//               with its nonce (results return in issue order), compares it
//               against the job target and reports winners through a one-deep
//               holding register.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous reset, active low
//               bus   - nonce_scheduler_if.slave (job / pipe / hash / found /
//                       status signals)
// Parameters  : WORD_S - nonce width
//               DELAY  - cycles from pipe_en to the matching hash_valid
// Options     : NONCE_STOP_ON_HIT_EN - when defined, the first hit seen while
//               issuing stops issue and drains the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_scheduler #(
    parameter int WORD_S = 32,
    parameter int DELAY  = 64
) (
    input  wire logic         clk,
    input  wire logic         reset,
    nonce_scheduler_if.slave  bus
);

    localparam int CNT_W = $clog2(DELAY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WORD_S-1:0] r_issue_nonce;
    logic [WORD_S:0]   r_remaining;
    logic [WORD_S-1:0] r_ret_nonce;
    logic [CNT_W-1:0]  r_inflight;
    logic [255:0]      r_target;
    logic              r_found_valid;
    logic [WORD_S-1:0] r_found_nonce;
    logic              r_hit_lost;

    logic              w_accept;
    logic              w_issue;
    logic              w_ret;
    logic              w_hit;
    logic              w_load_found;
    logic              w_last_issue;
    logic              w_stop_hit;
    logic              w_done;
    logic [WORD_S-1:0] w_span;

    // ------------------------------------------------------------------
    // Qualifiers
    // ------------------------------------------------------------------
    always_comb begin
        w_accept     = (r_state == IDLE) & bus.job_valid;
        // the abort cycle itself issues nothing
        w_issue      = (r_state == ISSUE) & ~bus.abort;
        // returns are only meaningful while a job is live
        w_ret        = (r_state != IDLE) & bus.hash_valid;
        w_hit        = w_ret & (bus.hash_in <= r_target);
        // a hit may refill the holding register in the cycle it is emptied
        w_load_found = w_hit & (~r_found_valid | bus.found_ready);
        w_last_issue = w_issue & (r_remaining == {{WORD_S{1'b0}}, 1'b1});
        // span is taken mod 2^WORD_S before widening, so end == start-1
        // yields the full 2^WORD_S range
        w_span       = bus.job_nonce_end - bus.job_nonce_start;
`ifdef NONCE_STOP_ON_HIT_EN
        w_stop_hit   = (r_state == ISSUE) & w_hit;
`else
        w_stop_hit   = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.abort || w_last_issue || w_stop_hit) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_inflight == '0) && !bus.hash_valid) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_nonce <= '0;
            r_remaining   <= '0;
            r_ret_nonce   <= '0;
            r_inflight    <= '0;
            r_target      <= '0;
            r_found_valid <= 1'b0;
            r_found_nonce <= '0;
            r_hit_lost    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_issue_nonce <= bus.job_nonce_start;
                r_ret_nonce   <= bus.job_nonce_start;
                r_remaining   <= {1'b0, w_span} + {{WORD_S{1'b0}}, 1'b1};
                r_target      <= bus.job_target;
                r_hit_lost    <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_issue_nonce <= r_issue_nonce + 1'b1;
                    r_remaining   <= r_remaining - 1'b1;
                end
                if (w_ret) begin
                    r_ret_nonce <= r_ret_nonce + 1'b1;
                end
                if (w_hit && !w_load_found) begin
                    r_hit_lost <= 1'b1;
                end
            end

            // simultaneous issue and return cancel out
            case ({w_issue, w_ret})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            if (w_load_found) begin
                r_found_valid <= 1'b1;
                r_found_nonce <= r_ret_nonce;
            end else if (bus.found_ready) begin
                r_found_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.job_ready   = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.pipe_en     = w_issue;
    assign bus.pipe_nonce  = w_issue ? r_issue_nonce : '0;
    assign bus.done        = w_done;
    assign bus.found_valid = r_found_valid;
    assign bus.found_nonce = r_found_nonce;
    assign bus.hit_lost    = r_hit_lost;

endmodule

`default_nettype wire

// File: tb/tb_nonce_scheduler.sv
// ============================================================================
// Module      : tb_nonce_scheduler
// Description : Directed self-checking bench for nonce_scheduler. A delay-line
//               model of the hash pipeline returns a programmable hash for
//               each issued nonce exactly DELAY cycles later.
// Options     : NONCE_STOP_ON_HIT_EN - selects stop-on-hit expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonce_scheduler;

    localparam int WORD_S = 32;
    localparam int DELAY  = 64;

    logic clk;
    logic reset;

    nonce_scheduler_if #(.WORD_S(WORD_S)) bus ();

    nonce_scheduler #(
        .WORD_S (WORD_S),
        .DELAY  (DELAY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // pipeline model
    bit          line_v [DELAY];
    logic [31:0] line_n [DELAY];
    logic [31:0]  hit_a, hit_b;
    logic [255:0] hit_hash, miss_hash;

    // per-cycle samples
    int          cyc_cnt = 0;
    int          s_idx;
    logic        s_pe, s_done, s_fv;
    logic [31:0] s_pn, s_fn;

    // per-job records
    logic [31:0] issued [$];
    logic [31:0] found  [$];
    int          t_acc, first_issue, done_cyc;

    function automatic logic [255:0] hash_of(input logic [31:0] n);
        if (n == hit_a || n == hit_b) return hit_hash;
        return miss_hash;
    endfunction

    // One clock cycle: present this cycle's pipeline return, sample the
    // DUT's outputs mid-cycle, feed the issue into the delay line, advance.
    task automatic cyc();
        bus.hash_valid = line_v[DELAY-1];
        bus.hash_in    = line_v[DELAY-1] ? hash_of(line_n[DELAY-1]) : '0;
        #1;
        s_idx  = cyc_cnt;
        s_pe   = bus.pipe_en;
        s_pn   = bus.pipe_nonce;
        s_done = bus.done;
        s_fv   = bus.found_valid;
        s_fn   = bus.found_nonce;
        for (int i = DELAY-1; i > 0; i--) begin
            line_v[i] = line_v[i-1];
            line_n[i] = line_n[i-1];
        end
        line_v[0] = s_pe;
        line_n[0] = s_pn;
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    // Offer a job, then run until done or the cycle budget runs out.
    task automatic run_job(input logic [31:0] st, input logic [31:0] en,
                           input logic [255:0] tg, input int abort_at,
                           input int budget);
        issued.delete();
        found.delete();
        first_issue = -1;
        done_cyc    = -1;
        bus.job_valid       = 1'b1;
        bus.job_nonce_start = st;
        bus.job_nonce_end   = en;
        bus.job_target      = tg;
        t_acc = cyc_cnt;
        cyc();
        bus.job_valid = 1'b0;
        for (int k = 0; k < budget && done_cyc < 0; k++) begin
            bus.abort = (abort_at >= 0) && (cyc_cnt == t_acc + abort_at);
            cyc();
            if (s_pe) begin
                issued.push_back(s_pn);
                if (first_issue < 0) first_issue = s_idx;
            end
            if (s_fv) found.push_back(s_fn);
            if (s_done) done_cyc = s_idx;
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pipe_en !== 1'b0 ||
            bus.pipe_nonce !== 32'h0 || bus.done !== 1'b0 || bus.hit_lost !== 1'b0 ||
            bus.found_valid !== 1'b0 || bus.found_nonce !== 32'h0)
            $display("FAIL reset_values: rdy=%b busy=%b pe=%b pn=%h done=%b lost=%b fv=%b fn=%h, required rdy=1 rest=0",
                     bus.job_ready, bus.busy, bus.pipe_en, bus.pipe_nonce, bus.done,
                     bus.hit_lost, bus.found_valid, bus.found_nonce);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_range();
        hit_a = 32'hDEAD_0000; hit_b = 32'hDEAD_0000;
        hit_hash = '0; miss_hash = '1;
        bus.found_ready = 1'b1;
        run_job(32'h10, 32'h13, '1, -1, 200);
        n_checks++;
        if (issued.size() !== 4) $display("FAIL basic_issue_count: got %0d required 4", issued.size());
        else n_pass++;
        for (int i = 0; i < issued.size() && i < 4; i++) begin
            n_checks++;
            if (issued[i] !== 32'h10 + i) $display("FAIL basic_pipe_nonce[%0d]: got %h required %h", i, issued[i], 32'h10 + i);
            else n_pass++;
        end
        n_checks++;
        if (first_issue !== t_acc + 1) $display("FAIL basic_first_issue: got %0d required %0d", first_issue, t_acc + 1);
        else n_pass++;
        n_checks++;
        if (found.size() !== 4) $display("FAIL basic_found_count: got %0d required 4", found.size());
        else n_pass++;
        for (int i = 0; i < found.size() && i < 4; i++) begin
            n_checks++;
            if (found[i] !== 32'h10 + i) $display("FAIL basic_found_nonce[%0d]: got %h required %h", i, found[i], 32'h10 + i);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc !== t_acc + 4 + DELAY + 1) $display("FAIL basic_done_cycle: got %0d required %0d", done_cyc, t_acc + 4 + DELAY + 1);
        else n_pass++;
        n_checks++;
        if (bus.job_ready !== 1'b1) $display("FAIL basic_ready_after_done: got %b required 1", bus.job_ready);
        else n_pass++;
    endtask

    task automatic test_wrap_range();
        logic [31:0] exp_w [4];
        exp_w = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        hit_a = 32'hDEAD_0000; hit_b = 32'hDEAD_0000;
        miss_hash = '1;
        bus.found_ready = 1'b1;
        run_job(32'hFFFF_FFFE, 32'h1, '0, -1, 200);
        n_checks++;
        if (issued.size() !== 4) $display("FAIL wrap_issue_count: got %0d required 4", issued.size());
        else n_pass++;
        for (int i = 0; i < issued.size() && i < 4; i++) begin
            n_checks++;
            if (issued[i] !== exp_w[i]) $display("FAIL wrap_pipe_nonce[%0d]: got %h required %h", i, issued[i], exp_w[i]);
            else n_pass++;
        end
        n_checks++;
        if (found.size() !== 0) $display("FAIL wrap_no_found: got %0d found required 0", found.size());
        else n_pass++;
        n_checks++;
        if (done_cyc !== t_acc + 4 + DELAY + 1) $display("FAIL wrap_done_cycle: got %0d required %0d", done_cyc, t_acc + 4 + DELAY + 1);
        else n_pass++;
    endtask

    task automatic test_single_hit();
        int          exp_cnt;
        logic [31:0] exp_last;
`ifdef NONCE_STOP_ON_HIT_EN
        exp_cnt  = 32'h150 - 32'h100 + DELAY + 1;
        exp_last = 32'h150 + DELAY;
`else
        exp_cnt  = 256;
        exp_last = 32'h1FF;
`endif
        hit_a = 32'h150; hit_b = 32'h150;
        hit_hash = 256'h5; miss_hash = '1;
        bus.found_ready = 1'b1;
        run_job(32'h100, 32'h1FF, {32'h0, {224{1'b1}}}, -1, 500);
        n_checks++;
        if (found.size() !== 1) $display("FAIL hit_found_count: got %0d required 1", found.size());
        else n_pass++;
        if (found.size() > 0) begin
            n_checks++;
            if (found[0] !== 32'h150) $display("FAIL hit_found_nonce: got %h required 00000150", found[0]);
            else n_pass++;
        end
        n_checks++;
        if (issued.size() !== exp_cnt) $display("FAIL hit_issue_count: got %0d required %0d", issued.size(), exp_cnt);
        else n_pass++;
        if (issued.size() > 0) begin
            n_checks++;
            if (issued[issued.size()-1] !== exp_last) $display("FAIL hit_last_nonce: got %h required %h", issued[issued.size()-1], exp_last);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc !== t_acc + exp_cnt + DELAY + 1) $display("FAIL hit_done_cycle: got %0d required %0d", done_cyc, t_acc + exp_cnt + DELAY + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        hit_a = 32'h20; hit_b = 32'h21;
        hit_hash = '0; miss_hash = '1;
        bus.found_ready = 1'b0;
        run_job(32'h20, 32'h23, '0, -1, 200);
        n_checks++;
        if (done_cyc < 0) $display("FAIL b2b_done_seen: got no done required done");
        else n_pass++;
        n_checks++;
        if (bus.found_valid !== 1'b1 || bus.found_nonce !== 32'h20)
            $display("FAIL b2b_found: got valid=%b nonce=%h required valid=1 nonce=00000020", bus.found_valid, bus.found_nonce);
        else n_pass++;
        n_checks++;
        if (bus.hit_lost !== 1'b1) $display("FAIL b2b_hit_lost: got %b required 1", bus.hit_lost);
        else n_pass++;
        bus.found_ready = 1'b1;
        cyc();
        n_checks++;
        if (bus.found_valid !== 1'b0) $display("FAIL b2b_found_drop: got %b required 0", bus.found_valid);
        else n_pass++;
        n_checks++;
        if (bus.hit_lost !== 1'b1) $display("FAIL b2b_hit_lost_sticky: got %b required 1", bus.hit_lost);
        else n_pass++;
    endtask

    task automatic test_abort();
        hit_a = 32'hDEAD_0000; hit_b = 32'hDEAD_0000;
        miss_hash = '1;
        bus.found_ready = 1'b1;
        run_job(32'h1000, 32'h1000 + 999, '0, 3, 300);
        n_checks++;
        if (issued.size() !== 2) $display("FAIL abort_issue_count: got %0d required 2", issued.size());
        else n_pass++;
        if (issued.size() == 2) begin
            n_checks++;
            if (issued[0] !== 32'h1000 || issued[1] !== 32'h1001)
                $display("FAIL abort_pipe_nonces: got %h %h required 00001000 00001001", issued[0], issued[1]);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc !== t_acc + 2 + DELAY + 1) $display("FAIL abort_done_cycle: got %0d required %0d", done_cyc, t_acc + 2 + DELAY + 1);
        else n_pass++;
        n_checks++;
        if (bus.job_ready !== 1'b1) $display("FAIL abort_ready: got %b required 1", bus.job_ready);
        else n_pass++;
        n_checks++;
        if (bus.hit_lost !== 1'b0) $display("FAIL accept_clears_hit_lost: got %b required 0", bus.hit_lost);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int fv_seen;
        int pe_seen;
        hit_a = 32'hDEAD_0000; hit_b = 32'hDEAD_0000;
        miss_hash = '0;              // every hash would be a hit if processed
        bus.found_ready = 1'b0;
        bus.job_valid       = 1'b1;
        bus.job_nonce_start = 32'h2000;
        bus.job_nonce_end   = 32'h20FF;
        bus.job_target      = '1;
        cyc();
        bus.job_valid = 1'b0;
        repeat (4) cyc();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.pipe_en !== 1'b1) $display("FAIL rst_pre_issue: got busy=%b pe=%b required 1 1", bus.busy, bus.pipe_en);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.job_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pipe_en !== 1'b0 ||
            bus.pipe_nonce !== 32'h0 || bus.done !== 1'b0 || bus.hit_lost !== 1'b0 ||
            bus.found_valid !== 1'b0 || bus.found_nonce !== 32'h0)
            $display("FAIL rst_async_outputs: rdy=%b busy=%b pe=%b pn=%h done=%b lost=%b fv=%b fn=%h, required rdy=1 rest=0",
                     bus.job_ready, bus.busy, bus.pipe_en, bus.pipe_nonce, bus.done,
                     bus.hit_lost, bus.found_valid, bus.found_nonce);
        else n_pass++;
        #1;
        reset = 1'b1;
        fv_seen = 0;
        pe_seen = 0;
        for (int k = 0; k < DELAY + 20; k++) begin
            cyc();
            if (s_fv) fv_seen++;
            if (s_pe) pe_seen++;
        end
        n_checks++;
        if (fv_seen !== 0 || pe_seen !== 0)
            $display("FAIL rst_stray_hash: got found_valid cycles=%0d issues=%0d required 0 0", fv_seen, pe_seen);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < DELAY; i++) begin
            line_v[i] = 1'b0;
            line_n[i] = '0;
        end
        hit_a = '0; hit_b = '0; hit_hash = '0; miss_hash = '1;
        bus.job_valid       = 1'b0;
        bus.job_nonce_start = '0;
        bus.job_nonce_end   = '0;
        bus.job_target      = '0;
        bus.abort           = 1'b0;
        bus.hash_valid      = 1'b0;
        bus.hash_in         = '0;
        bus.found_ready     = 1'b0;

        test_reset();
        test_basic_range();
        test_wrap_range();
        test_single_hit();
        test_back_to_back();
        test_abort();
        test_async_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
